multichannel_fir_filter: RTL
============================

Name: multichannel_fir_filter

Overview:
Time-multiplexed, multi-channel FIR filter for the audio path, with a run-time loadable coefficient bank. The block accepts one frame (one sample per channel) through a valid/ready handshake. It runs a single shared MAC over every tap of every channel, then emits one rounded, saturated output frame. Everything is single-clock on sample_clk, with no cross-domain trigger. It sits between the synth voice mixer and the I2S transmitter.

Parameters:
NUM_CH, 2, number of audio channels sharing the MAC
DATA_W, 16, signed sample width (input and output)
COEF_W, 16, signed coefficient width
NUM_TAPS, 24, taps per channel (>=2)
ACC_W, 40, signed accumulator width (>= DATA_W+COEF_W+clog2(NUM_TAPS))
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation

Ports:
sample_clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input frame valid
in_ready  out  1  block can accept a frame
in_data  in  NUM_CH*DATA_W  signed samples; channel c occupies bits [c*DATA_W +: DATA_W]
out_valid  out  1  one-cycle pulse: out_data updated
out_data  out  NUM_CH*DATA_W  filtered samples, same lane packing
coef_we  in  1  write strobe into the shadow coefficient bank
coef_addr  in  clog2(NUM_TAPS)  tap index to write
coef_wdata  in  COEF_W  signed coefficient value
coef_commit  in  1  request copy of shadow bank into active bank
commit_pending  out  1  commit requested but not yet applied

Behaviour:
- Reset (rst=1 at an edge):
  - Delay lines, accumulator, both coefficient banks and out_data clear to 0.
  - out_valid=0, commit_pending=0, FSM=IDLE.
  - Reset mid-MAC aborts the frame; no out_valid is produced for it.
- FSM has two states, IDLE and MAC. in_ready = (state==IDLE), combinational.
- IDLE:
  - An edge with in_valid && in_ready is the acceptance edge.
  - At that edge, each channel's delay line shifts (x[c][i] <= x[c][i-1], x[c][0] <= lane c of in_data).
  - The accumulator clears, the index clears, and the FSM goes to MAC.
  - in_valid while in_ready=0 is ignored; the source must hold the data.
- MAC:
  - One product coef_active[t]*x[c][t] is added per edge.
  - Index order is channel-major: c=0 over t=0..NUM_TAPS-1, then c=1, and so on.
  - The MAC lasts exactly NUM_CH*NUM_TAPS edges.
  - On each channel's last tap, the final sum (acc + product) is rounded and saturated into lane c of out_data, and the accumulator clears.
  - On the final product of the last channel: out_valid<=1 for one cycle, FSM->IDLE.
- Latency and throughput:
  - out_valid is high in the cycle following edge k+NUM_CH*NUM_TAPS, where k is the acceptance edge.
  - Earliest next acceptance is edge k+NUM_CH*NUM_TAPS+1.
- Arithmetic:
  - Products are full-precision signed; accumulation uses ACC_W bits with no internal overflow.
  - Result = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT; the rounding term is 0 when OUT_SHIFT=0.
  - The result is then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_data holds its value between out_valid pulses.
- Coefficients:
  - coef_we writes the shadow bank at any time; the active bank is unaffected.
  - coef_commit sets commit_pending.
  - At any edge with state==IDLE and commit_pending (including the commit edge itself), the shadow bank is copied to active and commit_pending clears.
  - A commit raised during MAC is deferred until IDLE, so the in-flight frame always uses a single coefficient set.
  - If commit and acceptance coincide, the accepted frame uses the new bank.
  - If coef_we and the copy coincide, the copy takes the pre-edge shadow contents; the write lands in shadow only.
  - coef_addr >= NUM_TAPS is ignored.

Test Plan:
- Impulse response (NUM_CH=2, NUM_TAPS=4, OUT_SHIFT=15):
  - Stimulus: load and commit coefficients {16384, 8192, -8192, 4096}; feed 32767 on ch0 and 0 on ch1, then zeros.
  - Required: ch0 outputs 16384, 8192, -8192, 4096, 0; ch1 outputs all 0.
- Latency and back-pressure:
  - Stimulus: hold in_valid=1 continuously.
  - Required: frames accepted every 9 cycles; out_valid pulses exactly 8 cycles after each acceptance edge; in_ready=0 throughout MAC.
- Saturation:
  - Stimulus: all coefficients 32767; four frames of 32767.
  - Required: output 32767. The same with -32768 inputs yields -32768.
- Deferred commit:
  - Stimulus: write new taps and pulse coef_commit mid-MAC.
  - Required: commit_pending=1 until IDLE; current frame uses old taps; next frame uses new taps.
- Reset mid-operation:
  - Stimulus: assert rst during MAC.
  - Required: no out_valid for that frame; out_data=0; in_ready=1 the cycle after rst deasserts; delay lines zero (impulse test repeats identically).

Source files
------------

// File: rtl/multichannel_fir_filter.sv
`default_nettype none
// ============================================================================
// Module   : multichannel_fir_filter
// Purpose  : Time-multiplexed multi-channel FIR. A single shared MAC walks
//            every tap of every channel (channel-major order), then emits one
//            rounded, saturated output frame. The coefficient bank is double
//            buffered: writes land in a shadow bank, and a commit copies it to
//            the active bank only while idle.
// Revision : 1.0 - initial release
// ============================================================================
module multichannel_fir_filter #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NUM_TAPS  = 24,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic                        sample_clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_CH*DATA_W-1:0]    in_data,
    output logic                        out_valid,
    output logic [NUM_CH*DATA_W-1:0]    out_data,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]           coef_wdata,
    input  logic                        coef_commit,
    output logic                        commit_pending
);

    localparam int c_TAP_W  = $clog2(NUM_TAPS);
    localparam int c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PROD_W = DATA_W + COEF_W;

    localparam logic [c_TAP_W-1:0] c_LAST_TAP = c_TAP_W'(NUM_TAPS - 1);
    localparam logic [c_CH_W-1:0]  c_LAST_CH  = c_CH_W'(NUM_CH - 1);
    localparam logic [c_TAP_W:0]   c_NUM_TAPS = (c_TAP_W + 1)'(NUM_TAPS);

    // Rounding constant is half an output LSB; it vanishes when no shift is applied.
    localparam logic signed [ACC_W:0] c_RND =
        (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << ((OUT_SHIFT > 0) ? (OUT_SHIFT - 1) : 0)) : '0;

    // Output clamp limits, in both the wide and the output domain.
    localparam logic signed [ACC_W:0]    c_MAX_W    = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0]    c_MIN_W    = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] c_SAT_HI   = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_SAT_LO   = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [DATA_W-1:0]   r_x        [NUM_CH][NUM_TAPS];
    logic signed [COEF_W-1:0]   r_coef_shd [NUM_TAPS];
    logic signed [COEF_W-1:0]   r_coef_act [NUM_TAPS];
    logic signed [ACC_W-1:0]    r_acc;
    logic [c_CH_W-1:0]          r_ch;
    logic [c_TAP_W-1:0]         r_tap;
    logic                       r_out_valid;
    logic [NUM_CH*DATA_W-1:0]   r_out_data;
    logic                       r_commit_pending;

    logic                       w_accept;
    logic                       w_last_tap;
    logic                       w_last_ch;
    logic                       w_do_copy;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W:0]      w_rnd;
    logic signed [ACC_W:0]      w_shift;
    logic signed [DATA_W-1:0]   w_sat;

    assign in_ready       = (r_state == IDLE);
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign commit_pending = r_commit_pending;

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_last_tap = (r_tap == c_LAST_TAP);
    assign w_last_ch  = (r_ch == c_LAST_CH);
    // A commit on this very edge counts as pending, so an idle commit applies at once.
    assign w_do_copy  = (r_state == IDLE) && (r_commit_pending || coef_commit);

    // Full-precision product, sign-extended into the accumulator width.
    assign w_prod  = r_coef_act[r_tap] * r_x[r_ch][r_tap];
    assign w_sum   = r_acc + {{(ACC_W - c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    // One guard bit keeps the rounding add from wrapping near full scale.
    assign w_rnd   = {w_sum[ACC_W-1], w_sum} + c_RND;
    assign w_shift = w_rnd >>> OUT_SHIFT;
    assign w_sat   = (w_shift > c_MAX_W) ? c_SAT_HI :
                     (w_shift < c_MIN_W) ? c_SAT_LO : w_shift[DATA_W-1:0];

    // State register.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one frame in, exactly NUM_CH*NUM_TAPS MAC edges, back to idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = MAC;
            MAC:     if (w_last_tap && w_last_ch) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Shadow writes at any time; shadow-to-active copy only while idle.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                r_coef_shd[t] <= '0;
                r_coef_act[t] <= '0;
            end
            r_commit_pending <= 1'b0;
        end else begin
            if (coef_we && ({1'b0, coef_addr} < c_NUM_TAPS)) begin
                r_coef_shd[coef_addr] <= coef_wdata;
            end
            if (w_do_copy) begin
                r_coef_act       <= r_coef_shd;
                r_commit_pending <= 1'b0;
            end else if (coef_commit) begin
                r_commit_pending <= 1'b1;
            end
        end
    end

    // Per-channel delay lines advance once per accepted frame.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_x[c][t] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = NUM_TAPS - 1; t > 0; t--) begin
                    r_x[c][t] <= r_x[c][t-1];
                end
                r_x[c][0] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // MAC sequencing: accumulate per tap, retire each channel on its last tap.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_ch        <= '0;
            r_tap       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_acc <= '0;
                r_ch  <= '0;
                r_tap <= '0;
            end else if (r_state == MAC) begin
                if (w_last_tap) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (r_ch == c_CH_W'(c)) begin
                            r_out_data[c*DATA_W +: DATA_W] <= w_sat;
                        end
                    end
                    r_acc <= '0;
                    r_tap <= '0;
                    if (w_last_ch) begin
                        r_out_valid <= 1'b1;
                    end else begin
                        r_ch <= r_ch + c_CH_W'(1);
                    end
                end else begin
                    r_acc <= w_sum;
                    r_tap <= r_tap + c_TAP_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
